mod12_step_sequencer: RTL and testbench



---
 rtl/mod12_pkg.sv | 38 +++
 rtl/mod12_ud_core.sv | 47 ++++
 rtl/mod12_step_sequencer.sv | 135 +++++++++++++
 tb/tb_mod12_step_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod12_pkg.sv
// mod12_pkg
// Shared definitions for the mod-12 step sequencer slice: the modulus and
// widths of the position and step count, the controller state type, and the
// helper functions for a single modulo step and its wrap detection.
package mod12_pkg;

  localparam int MOD    = 12;
  localparam int POS_W  = 4;
  localparam int STEP_W = 4;

  // Largest legal position, kept at position width so comparisons stay width-matched
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(MOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_t;

  // Single modulo step; dir=1 counts up, dir=0 counts down
  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] pos,
                                                input logic             dir);
    logic [POS_W-1:0] result;
    if (dir) begin
      result = (pos == POS_MAX) ? '0 : pos + 1'b1;
    end else begin
      result = (pos == '0) ? POS_MAX : pos - 1'b1;
    end
    return result;
  endfunction

  // True when the step taken from pos in direction dir wraps around the modulus
  function automatic logic step_wraps(input logic [POS_W-1:0] pos,
                                      input logic             dir);
    return dir ? (pos == POS_MAX) : (pos == '0);
  endfunction

endpackage

// File: rtl/mod12_ud_core.sv
// mod12_ud_core
// Modulo-12 up/down position register with preload.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (pos=0, wrap=0)
//   i_en       : take one step this cycle
//   i_dir      : step direction, 1 = up, 0 = down
//   i_load     : preload position (has priority over i_en)
//   i_loadVal  : preload value, caller guarantees it is < MOD
//   o_pos      : registered position
//   o_wrap     : registered one-cycle pulse after a wrapping step
module mod12_ud_core
  import mod12_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [POS_W-1:0] i_loadVal,
  output logic [POS_W-1:0] o_pos,
  output logic             o_wrap
);

  logic [POS_W-1:0] r_pos;
  logic             r_wrap;

  // Position register: load wins over stepping; wrap is only ever a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos  <= '0;
      r_wrap <= 1'b0;
    end else if (i_load) begin
      r_pos  <= i_loadVal;
      r_wrap <= 1'b0;
    end else if (i_en) begin
      r_pos  <= next_pos(r_pos, i_dir);
      r_wrap <= step_wraps(r_pos, i_dir);
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign o_pos  = r_pos;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/mod12_step_sequencer.sv
// mod12_step_sequencer
// Command-driven controller that moves the mod-12 position N steps up or down,
// with optional preload, over a valid/ready handshake.
// Ports:
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   i_cmdValid     : command present
//   o_cmdReady     : command can be accepted (IDLE only)
//   i_cmdDir       : 1 = up, 0 = down
//   i_cmdSteps     : number of single-count steps
//   i_cmdLoad      : preload position before stepping
//   i_cmdLoadVal   : preload value
//   i_hold         : freeze stepping while running
//   o_pos          : current position
//   o_busy         : high while running or finishing
//   o_done         : one-cycle completion pulse
//   o_err          : one-cycle pulse with o_done for an illegal preload
//   o_wrap         : one-cycle pulse after a wrapping step
module mod12_step_sequencer
  import mod12_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmdValid,
  output logic              o_cmdReady,
  input  logic              i_cmdDir,
  input  logic [STEP_W-1:0] i_cmdSteps,
  input  logic              i_cmdLoad,
  input  logic [POS_W-1:0]  i_cmdLoadVal,
  input  logic              i_hold,
  output logic [POS_W-1:0]  o_pos,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_wrap
);

  seqState_t         r_state;
  seqState_t         w_stateNext;
  logic [STEP_W-1:0] r_remaining;
  logic              r_dir;
  logic              r_errPending;

  logic w_accept;
  logic w_loadIllegal;
  logic w_coreLoad;
  logic w_coreEn;

  // Handshake decode; an out-of-range preload is rejected without touching pos
  assign w_accept      = (r_state == IDLE) && i_cmdValid;
  assign w_loadIllegal = i_cmdLoad && (i_cmdLoadVal > POS_MAX);
  assign w_coreLoad    = w_accept && i_cmdLoad && !w_loadIllegal;
  assign w_coreEn      = (r_state == RUN) && !i_hold;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: zero-step and illegal-load commands go straight to DONE
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_loadIllegal || (i_cmdSteps == '0)) begin
            w_stateNext = DONE;
          end else begin
            w_stateNext = RUN;
          end
        end
      end
      RUN: begin
        if (!i_hold && (r_remaining == STEP_W'(1))) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Command bookkeeping: latched direction, steps still to go, pending error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining  <= '0;
      r_dir        <= 1'b0;
      r_errPending <= 1'b0;
    end else if (w_accept) begin
      r_remaining  <= i_cmdSteps;
      r_dir        <= i_cmdDir;
      r_errPending <= w_loadIllegal;
    end else if (w_coreEn) begin
      r_remaining  <= r_remaining - 1'b1;
    end
  end

  // Output decode from state only, so no input reaches an output combinationally
  always_comb begin
    o_cmdReady = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_err      = 1'b0;
    unique case (r_state)
      IDLE: o_cmdReady = 1'b1;
      RUN:  o_busy     = 1'b1;
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        o_err  = r_errPending;
      end
      default: o_cmdReady = 1'b0;
    endcase
  end

  mod12_ud_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_coreEn),
    .i_dir     (r_dir),
    .i_load    (w_coreLoad),
    .i_loadVal (i_cmdLoadVal),
    .o_pos     (o_pos),
    .o_wrap    (o_wrap)
  );

endmodule

// File: tb/tb_mod12_step_sequencer.sv
// tb_mod12_step_sequencer
// Directed bench for mod12_step_sequencer; expected values are hand-computed.
module tb_mod12_step_sequencer;
  import mod12_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              cmdValid;
  logic              cmdReady;
  logic              cmdDir;
  logic [STEP_W-1:0] cmdSteps;
  logic              cmdLoad;
  logic [POS_W-1:0]  cmdLoadVal;
  logic              hold;
  logic [POS_W-1:0]  pos;
  logic              busy;
  logic              done;
  logic              err;
  logic              wrap;

  int checkCount = 0;
  int failCount  = 0;

  mod12_step_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmdValid   (cmdValid),
    .o_cmdReady   (cmdReady),
    .i_cmdDir     (cmdDir),
    .i_cmdSteps   (cmdSteps),
    .i_cmdLoad    (cmdLoad),
    .i_cmdLoadVal (cmdLoadVal),
    .i_hold       (hold),
    .o_pos        (pos),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_wrap       (wrap)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present a command and wait (bounded) for its acceptance edge T; returns just after T
  task automatic applyStimulus(input logic dir, input int steps, input logic load, input int loadVal);
    int waitCycles;
    cmdDir     = dir;
    cmdSteps   = STEP_W'(steps);
    cmdLoad    = load;
    cmdLoadVal = POS_W'(loadVal);
    cmdValid   = 1'b1;
    waitCycles = 0;
    while (!cmdReady && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!cmdReady) checkOutput("acceptTimeout", 0, 1);
    @(posedge clk);
    #1 cmdValid = 1'b0;
  endtask

  // Advance to the next falling edge and check position, done and wrap
  task automatic stepCheck(input string tag, input int expPos, input int expDone, input int expWrap);
    @(negedge clk);
    checkOutput({tag, ".pos"},  int'(pos),  expPos);
    checkOutput({tag, ".done"}, int'(done), expDone);
    checkOutput({tag, ".wrap"}, int'(wrap), expWrap);
  endtask

  // Advance one cycle and check the controller is back in IDLE
  task automatic idleCheck(input string tag, input int expPos);
    @(negedge clk);
    checkOutput({tag, ".ready"}, int'(cmdReady), 1);
    checkOutput({tag, ".busy"},  int'(busy),     0);
    checkOutput({tag, ".done"},  int'(done),     0);
    checkOutput({tag, ".pos"},   int'(pos),      expPos);
  endtask

  initial begin
    int acceptCycle[3];
    int acceptCount;
    int cyc;
    int donePulses;

    rst_n      = 1'b0;
    cmdValid   = 1'b0;
    cmdDir     = 1'b0;
    cmdSteps   = '0;
    cmdLoad    = 1'b0;
    cmdLoadVal = '0;
    hold       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst.pos",  int'(pos),  0);
    checkOutput("rst.busy", int'(busy), 0);
    checkOutput("rst.done", int'(done), 0);
    checkOutput("rst.err",  int'(err),  0);
    checkOutput("rst.wrap", int'(wrap), 0);
    rst_n = 1'b1;
    idleCheck("rstIdle", 0);

    // Up 5 from 0
    applyStimulus(1'b1, 5, 1'b0, 0);
    stepCheck("up5.t0", 0, 0, 0);
    checkOutput("up5.busy", int'(busy), 1);
    checkOutput("up5.ready", int'(cmdReady), 0);
    stepCheck("up5.t1", 1, 0, 0);
    stepCheck("up5.t2", 2, 0, 0);
    stepCheck("up5.t3", 3, 0, 0);
    stepCheck("up5.t4", 4, 0, 0);
    stepCheck("up5.t5", 5, 1, 0);
    checkOutput("up5.err", int'(err), 0);
    idleCheck("up5.idle", 5);

    // Load 10, up 4: wraps once on 11 -> 0
    applyStimulus(1'b1, 4, 1'b1, 10);
    stepCheck("ld10.t0", 10, 0, 0);
    stepCheck("ld10.t1", 11, 0, 0);
    stepCheck("ld10.t2", 0,  0, 1);
    stepCheck("ld10.t3", 1,  0, 0);
    stepCheck("ld10.t4", 2,  1, 0);
    idleCheck("ld10.idle", 2);

    // Down 1 to reach 1, then down 3: 0, 11, 10 with wrap after 0 -> 11
    applyStimulus(1'b0, 1, 1'b0, 0);
    stepCheck("dn1.t0", 2, 0, 0);
    stepCheck("dn1.t1", 1, 1, 0);
    idleCheck("dn1.idle", 1);
    applyStimulus(1'b0, 3, 1'b0, 0);
    stepCheck("dn3.t0", 1,  0, 0);
    stepCheck("dn3.t1", 0,  0, 0);
    stepCheck("dn3.t2", 11, 0, 1);
    stepCheck("dn3.t3", 10, 1, 0);
    idleCheck("dn3.idle", 10);

    // Illegal preload 12: err+done one cycle after accept, pos unchanged
    applyStimulus(1'b1, 3, 1'b1, 12);
    stepCheck("ld12.t0", 10, 1, 0);
    checkOutput("ld12.err", int'(err), 1);
    idleCheck("ld12.idle", 10);
    checkOutput("ld12.errClear", int'(err), 0);

    // Up 6 with 3 hold cycles mid-run; a command offered while busy is ignored
    applyStimulus(1'b1, 6, 1'b0, 0);
    stepCheck("hold.t0", 10, 0, 0);
    stepCheck("hold.t1", 11, 0, 0);
    stepCheck("hold.t2", 0,  0, 1);
    stepCheck("hold.t3", 1,  0, 0);
    hold       = 1'b1;
    cmdValid   = 1'b1;
    cmdDir     = 1'b0;
    cmdSteps   = STEP_W'(2);
    cmdLoad    = 1'b1;
    cmdLoadVal = POS_W'(5);
    for (int i = 0; i < 3; i++) begin
      stepCheck("hold.frz", 1, 0, 0);
      checkOutput("hold.busy",  int'(busy),     1);
      checkOutput("hold.ready", int'(cmdReady), 0);
    end
    hold     = 1'b0;
    cmdValid = 1'b0;
    stepCheck("hold.t7", 2, 0, 0);
    stepCheck("hold.t8", 3, 0, 0);
    stepCheck("hold.t9", 4, 1, 0);
    idleCheck("hold.idle", 4);

    // Zero steps with load 7
    applyStimulus(1'b0, 0, 1'b1, 7);
    stepCheck("z7.t0", 7, 1, 0);
    checkOutput("z7.err", int'(err), 0);
    idleCheck("z7.idle", 7);

    // Back-to-back up-2 commands with cmd_valid held: accepts every 4 cycles
    cmdDir     = 1'b1;
    cmdSteps   = STEP_W'(2);
    cmdLoad    = 1'b0;
    cmdLoadVal = '0;
    cmdValid   = 1'b1;
    acceptCount = 0;
    cyc = 0;
    while (acceptCount < 3 && cyc < 40) begin
      if (cmdReady) begin
        acceptCycle[acceptCount] = cyc;
        acceptCount++;
      end
      if (acceptCount < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("b2b.count", acceptCount, 3);
    checkOutput("b2b.gap1", acceptCycle[1] - acceptCycle[0], 4);
    checkOutput("b2b.gap2", acceptCycle[2] - acceptCycle[1], 4);
    @(posedge clk);
    #1 cmdValid = 1'b0;
    stepCheck("b2b.t0", 11, 0, 0);
    stepCheck("b2b.t1", 0,  0, 1);
    stepCheck("b2b.t2", 1,  1, 0);
    idleCheck("b2b.idle", 1);

    // Asynchronous reset mid-run, between clock edges
    applyStimulus(1'b1, 5, 1'b0, 0);
    stepCheck("ar.t0", 1, 0, 0);
    stepCheck("ar.t1", 2, 0, 0);
    stepCheck("ar.t2", 3, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar.pos",  int'(pos),  0);
    checkOutput("ar.busy", int'(busy), 0);
    checkOutput("ar.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    donePulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) donePulses++;
    end
    checkOutput("ar.noDone", donePulses, 0);
    checkOutput("ar.posIdle", int'(pos), 0);
    checkOutput("ar.ready", int'(cmdReady), 1);
    applyStimulus(1'b1, 2, 1'b0, 0);
    stepCheck("ar2.t0", 0, 0, 0);
    stepCheck("ar2.t1", 1, 0, 0);
    stepCheck("ar2.t2", 2, 1, 0);
    idleCheck("ar2.idle", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
